// File: rtl/blit_addr_pipe.sv
// -----------------------------------------------------------------------------
// blit_addr_pipe
//
// Blitter address stage. It turns a per-pixel (x,y) request into a destination
// byte address and a source byte address, and clips the write against a signed
// window. It is a two-register elastic pipe: S1 computes, S2 is the output
// register. It sustains one pixel per clock with full valid/ready back-pressure.
//
// Optional feature: define BLIT_CLIP_COUNT_EN to build the clipped-pixel
// counter. Without it, clip_count is tied to zero and clip_count_clr is ignored.
//
// Ports
//   clock, reset_n         single rising-edge clock, async active-low reset
//   dest_addr/bpl/bpp      destination base, bytes per line, pixel size code
//   src_addr/bpl/bpp       source base, bytes per line, pixel size code
//   clip_x1/y1, x2/y2      signed window: min inclusive, max exclusive
//   in_valid/in_ready      request handshake
//   in_dest_x/y            signed destination coordinate
//   in_src_x/y             unsigned source coordinate
//   in_write, in_op        write request and operation (PEN/SRC/MONO/rsvd)
//   out_valid/out_ready    result handshake
//   out_dest_addr          destination byte address
//   out_src_addr           source byte address
//   out_src_bit_index      bit index within the source byte (MONO)
//   out_write, out_op      clipped write enable, operation passthrough
//   clip_count_clr         synchronous clear of clip_count
//   clip_count             saturating count of clipped writes
// -----------------------------------------------------------------------------
module blit_addr_pipe #(
   parameter int ADDR_W     = 26,
   parameter int SRC_ADDR_W = 32,
   parameter int COORD_W    = 16,
   parameter int CNT_W      = 24
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     dest_addr,
   input  logic [COORD_W-1:0]    dest_bpl,
   input  logic [1:0]            dest_bpp,
   input  logic [SRC_ADDR_W-1:0] src_addr,
   input  logic [COORD_W-1:0]    src_bpl,
   input  logic [1:0]            src_bpp,
   input  logic [COORD_W-1:0]    clip_x1,
   input  logic [COORD_W-1:0]    clip_y1,
   input  logic [COORD_W-1:0]    clip_x2,
   input  logic [COORD_W-1:0]    clip_y2,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [COORD_W-1:0]    in_dest_x,
   input  logic [COORD_W-1:0]    in_dest_y,
   input  logic [COORD_W-1:0]    in_src_x,
   input  logic [COORD_W-1:0]    in_src_y,
   input  logic                  in_write,
   input  logic [1:0]            in_op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_W-1:0]     out_dest_addr,
   output logic [SRC_ADDR_W-1:0] out_src_addr,
   output logic [2:0]            out_src_bit_index,
   output logic                  out_write,
   output logic [1:0]            out_op,
   input  logic                  clip_count_clr,
   output logic [CNT_W-1:0]      clip_count
);

   typedef enum logic [1:0] {
      OP_PEN  = 2'd0,
      OP_SRC  = 2'd1,
      OP_MONO = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   // Elastic handshake: a stage may load whenever it is empty or its contents
   // are leaving on this edge.
   logic s1_valid;
   logic s1_en;
   logic s2_en;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   // ---------------------------------------------------------------- S1 math
   logic [1:0]            dest_shift;
   logic [1:0]            src_shift;
   logic [ADDR_W-1:0]     dest_calc;
   logic [SRC_ADDR_W-1:0] src_line;
   logic [SRC_ADDR_W-1:0] src_calc;
   logic [2:0]            bit_calc;
   logic                  in_window;
   logic                  write_calc;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      src_calc   = '0;
      bit_calc   = 3'd0;

      // The reserved pixel size code (3) behaves as 8bpp.
      dest_shift = (dest_bpp == 2'd3) ? 2'd0 : dest_bpp;
      src_shift  = (src_bpp  == 2'd3) ? 2'd0 : src_bpp;

      // The destination coordinates are signed. Sign-extending them to the
      // address width makes a plain unsigned add/multiply wrap correctly,
      // modulo 2^ADDR_W.
      dest_calc  = dest_addr
                 + (ADDR_W'($signed(in_dest_x)) << dest_shift)
                 + ADDR_W'($signed(in_dest_y)) * ADDR_W'(dest_bpl);

      src_line   = SRC_ADDR_W'(in_src_y) * SRC_ADDR_W'(src_bpl);

      case (op_e'(in_op))
         OP_SRC: begin
            src_calc = src_addr + (SRC_ADDR_W'(in_src_x) << src_shift) + src_line;
         end
         OP_MONO: begin
            src_calc = src_addr + (SRC_ADDR_W'(in_src_x) >> 3) + src_line;
            bit_calc = in_src_x[2:0];
         end
         default: ;
      endcase

      // An empty window (min >= max) fails one of these tests for every pixel.
      in_window  = ($signed(in_dest_x) >= $signed(clip_x1)) &&
                   ($signed(in_dest_x) <  $signed(clip_x2)) &&
                   ($signed(in_dest_y) >= $signed(clip_y1)) &&
                   ($signed(in_dest_y) <  $signed(clip_y2));
      write_calc = in_write && in_window && (in_op != OP_RSVD);
   end

   // ------------------------------------------------------------- S1 register
   logic [ADDR_W-1:0]     s1_dest;
   logic [SRC_ADDR_W-1:0] s1_src;
   logic [2:0]            s1_bit;
   logic                  s1_write;
   logic [1:0]            s1_op;
`ifdef BLIT_CLIP_COUNT_EN
   logic                  s1_in_write;
   logic                  s2_in_write;
`endif

   // NOTE: sequential state uses non-blocking assignments only. The datapath
   // flops are reset too, so every out_* reads zero while in reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid    <= 1'b0;
         s1_dest     <= '0;
         s1_src      <= '0;
         s1_bit      <= '0;
         s1_write    <= 1'b0;
         s1_op       <= '0;
`ifdef BLIT_CLIP_COUNT_EN
         s1_in_write <= 1'b0;
`endif
      end else if (s1_en) begin
         s1_valid    <= in_valid;
         s1_dest     <= dest_calc;
         s1_src      <= src_calc;
         s1_bit      <= bit_calc;
         s1_write    <= write_calc;
         s1_op       <= in_op;
`ifdef BLIT_CLIP_COUNT_EN
         s1_in_write <= in_write;
`endif
      end
   end

   // ------------------------------------------------------- S2 output register
   // S2 loads only when empty or draining, so out_* stay stable under stall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid         <= 1'b0;
         out_dest_addr     <= '0;
         out_src_addr      <= '0;
         out_src_bit_index <= '0;
         out_write         <= 1'b0;
         out_op            <= '0;
`ifdef BLIT_CLIP_COUNT_EN
         s2_in_write       <= 1'b0;
`endif
      end else if (s2_en) begin
         out_valid         <= s1_valid;
         out_dest_addr     <= s1_dest;
         out_src_addr      <= s1_src;
         out_src_bit_index <= s1_bit;
         out_write         <= s1_write;
         out_op            <= s1_op;
`ifdef BLIT_CLIP_COUNT_EN
         s2_in_write       <= s1_in_write;
`endif
      end
   end

   // --------------------------------------------------------- clip counter
`ifdef BLIT_CLIP_COUNT_EN
   logic clip_event;

   assign clip_event = out_valid && out_ready && s2_in_write && !out_write;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clip_count <= '0;
      end else if (clip_count_clr) begin
         clip_count <= '0;
      end else if (clip_event && (clip_count != {CNT_W{1'b1}})) begin
         clip_count <= clip_count + 1'b1;
      end
   end
`else
   logic unused_clip_count_clr;

   assign unused_clip_count_clr = clip_count_clr;
   assign clip_count            = '0;
`endif

endmodule
